// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter that shares one sprite-sheet ROM read port between NUM_REQ draw pipelines.
// Optional statistics counters are compiled in with `define SPRITE_FETCH_STATS_EN.
module sprite_fetch_arbiter #(
  parameter int          NUM_REQ = 2,
  parameter int          SHEET_W = 512,
  parameter int          SHEET_H = 96,
  parameter int          RD_LAT  = 1,
  parameter logic [7:0]  TRANSP  = 8'h00
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*10-1:0]  req_x,
  input  logic [NUM_REQ*8-1:0]   req_y,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_data,
  output logic [19:0]            R_ADDR,
  input  logic [7:0]             rom_data
`ifdef SPRITE_FETCH_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [NUM_REQ*16-1:0]  grant_cnt,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int X_SHIFT = $clog2(SHEET_W);

  typedef struct packed {
    logic               vld;
    logic [NUM_REQ-1:0] owner;
    logic               oor;
  } stage_t;

  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [7:0]         rsp_data_q;
  logic [19:0]        raddr_q;
  logic [PTR_W-1:0]   ptr_q;
  stage_t             pipe_q [RD_LAT+1];

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_d;
  logic [9:0]         sel_x;
  logic [7:0]         sel_y;
  logic [19:0]        addr_calc;
  logic               sel_oor;
  stage_t             stage_d;
  int                 idx;

  // Walk the ring from ptr backwards so the last hit written is the first one at or after ptr.
  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    eligible = req & ~ack_q;
    grant    = '0;
    win_idx  = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        win_idx    = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    sel_x     = req_x[int'(win_idx)*10 +: 10];
    sel_y     = req_y[int'(win_idx)*8 +: 8];
    addr_calc = (20'(sel_y) << X_SHIFT) + 20'(sel_x);
    sel_oor   = (32'(sel_x) >= unsigned'(SHEET_W)) || (32'(sel_y) >= unsigned'(SHEET_H));
    ptr_d     = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    stage_d   = '{vld: |grant, owner: grant, oor: sel_oor};
  end

  // NOTE: all state updates use non-blocking assignments so the shift stages read last cycle's values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      raddr_q     <= '0;
      ptr_q       <= '0;
      for (int s = 0; s <= RD_LAT; s++) pipe_q[s] <= '0;
    end else begin
      ack_q <= grant;
      if (|grant) begin
        ptr_q <= ptr_d;
        if (!sel_oor) raddr_q <= addr_calc;
      end
      pipe_q[0] <= stage_d;
      for (int s = 1; s <= RD_LAT; s++) pipe_q[s] <= pipe_q[s-1];
      // The last stage lines up with the ROM's registered data for the address issued at ack time.
      rsp_valid_q <= pipe_q[RD_LAT].vld ? pipe_q[RD_LAT].owner : '0;
      if (pipe_q[RD_LAT].vld) rsp_data_q <= pipe_q[RD_LAT].oor ? TRANSP : rom_data;
    end
  end

  assign ack       = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign R_ADDR    = raddr_q;

`ifdef SPRITE_FETCH_STATS_EN
  logic [15:0] gcnt_q [NUM_REQ];
  logic [15:0] stall_q;
  logic        any_stall;

  // A requester stalls in any cycle it holds req without winning, including the cycle of its own ack.
  assign any_stall = |(req & ~grant);

  always_ff @(posedge Clk) begin
    if (Reset || stats_clr) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (gcnt_q[i] != 16'hFFFF)) gcnt_q[i] <= gcnt_q[i] + 16'd1;
      end
      if (any_stall && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
    assign grant_cnt[gi*16 +: 16] = gcnt_q[gi];
  end
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Directed self-checking bench for sprite_fetch_arbiter with a 1-cycle registered ROM model.
// Stats checks are compiled in when SPRITE_FETCH_STATS_EN is defined.
module tb_sprite_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [19:0] req_x = '0;
  logic [15:0] req_y = '0;
  logic [1:0]  ack;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [19:0] r_addr;
  logic [7:0]  rom_q;
`ifdef SPRITE_FETCH_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  logic [1:0] ea [8];
  logic [1:0] ev;

  sprite_fetch_arbiter #(
    .NUM_REQ(2), .SHEET_W(512), .SHEET_H(96), .RD_LAT(1), .TRANSP(8'h00)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .R_ADDR    (r_addr),
    .rom_data  (rom_q)
`ifdef SPRITE_FETCH_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM model: contents equal the low address byte, registered output.
  always @(posedge clk) rom_q <= r_addr[7:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_coord(input int i, input logic [9:0] x, input logic [7:0] y);
    req_x[i*10 +: 10] = x;
    req_y[i*8 +: 8]   = y;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_ack",       32'(ack),       32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data",  32'(rsp_data),  32'h0);
    check("rst_raddr",     32'(r_addr),    32'h0);
    rst = 1'b0;

    // Single fetch from requester 0: x=5, y=2 -> 2*512+5 = 1029
    set_coord(0, 10'd5, 8'd2);
    req = 2'b01;
    tick();
    check("single_ack",   32'(ack),    32'h1);
    check("single_raddr", 32'(r_addr), 32'd1029);
    req = 2'b00;
    tick();
    check("single_ack_low",    32'(ack),       32'h0);
    check("single_rsp_early",  32'(rsp_valid), 32'h0);
    tick();
    check("single_rsp_valid",  32'(rsp_valid), 32'h1);
    check("single_rsp_data",   32'(rsp_data),  32'h05);
    tick();
    check("single_rsp_pulse",  32'(rsp_valid), 32'h0);
    check("single_data_hold",  32'(rsp_data),  32'h05);

    // Both requesting continuously; pointer is at 1 after the previous grant to 0.
    // Requester 1 at x=7, y=3 -> 1543 (low byte 07).
    set_coord(1, 10'd7, 8'd3);
    ea = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
    req = 2'b11;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) req = 2'b00;
      tick();
      check("rr_ack", 32'(ack), 32'(ea[k]));
      ev = (k >= 2) ? ea[k-2] : 2'b00;
      check("rr_rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev != 2'b00) check("rr_rsp_data", 32'(rsp_data), (ev == 2'b01) ? 32'h05 : 32'h07);
    end

    // Out-of-range X on requester 1: acked, address held, TRANSP returned.
    set_coord(1, 10'd600, 8'd0);
    req = 2'b10;
    tick();
    check("oorx_ack",   32'(ack),    32'h2);
    check("oorx_raddr", 32'(r_addr), 32'd1029);
    req = 2'b00;
    tick();
    tick();
    check("oorx_rsp_valid", 32'(rsp_valid), 32'h2);
    check("oorx_rsp_data",  32'(rsp_data),  32'h00);

    // Reset during the ack cycle discards the fetch and returns the pointer to 0.
    req = 2'b01;
    tick();
    check("rstmid_ack",   32'(ack),    32'h1);
    check("rstmid_raddr", 32'(r_addr), 32'd1029);
    rst = 1'b1;
    req = 2'b00;
    tick();
    check("rstmid_ack_clr", 32'(ack),    32'h0);
    check("rstmid_raddr0",  32'(r_addr), 32'h0);
    rst = 1'b0;
    tick();
    check("rstmid_rsp_a", 32'(rsp_valid), 32'h0);
    tick();
    check("rstmid_rsp_b",  32'(rsp_valid), 32'h0);
    check("rstmid_data0",  32'(rsp_data),  32'h0);
    set_coord(1, 10'd7, 8'd3);
    req = 2'b11;
    tick();
    check("rstmid_ptr0", 32'(ack), 32'h1);
    req = 2'b00;
    tick();
    tick();
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rstmid_rsp_data",  32'(rsp_data),  32'h05);

    // Last in-range byte: x=511, y=95 -> 49151 (low byte FF).
    set_coord(0, 10'd511, 8'd95);
    req = 2'b01;
    tick();
    check("edge_ack",   32'(ack),    32'h1);
    check("edge_raddr", 32'(r_addr), 32'd49151);
    req = 2'b00;
    tick();
    tick();
    check("edge_rsp_valid", 32'(rsp_valid), 32'h1);
    check("edge_rsp_data",  32'(rsp_data),  32'hFF);

    // y=96 is just past the sheet.
    set_coord(0, 10'd0, 8'd96);
    req = 2'b01;
    tick();
    check("oory_ack",   32'(ack),    32'h1);
    check("oory_raddr", 32'(r_addr), 32'd49151);
    req = 2'b00;
    tick();
    tick();
    check("oory_rsp_valid", 32'(rsp_valid), 32'h1);
    check("oory_rsp_data",  32'(rsp_data),  32'h00);

`ifdef SPRITE_FETCH_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr_g0",    32'(grant_cnt[15:0]),  32'h0);
    check("stats_clr_stall", 32'(stall_cnt),        32'h0);
    set_coord(0, 10'd5, 8'd2);
    set_coord(1, 10'd7, 8'd3);
    req = 2'b11;
    for (int k = 0; k < 10; k++) tick();
    check("stats_g0",    32'(grant_cnt[15:0]),  32'd5);
    check("stats_g1",    32'(grant_cnt[31:16]), 32'd5);
    check("stats_stall", 32'(stall_cnt),        32'd10);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    req = 2'b00;
    check("stats_clr2_g0",    32'(grant_cnt[15:0]),  32'h0);
    check("stats_clr2_g1",    32'(grant_cnt[31:16]), 32'h0);
    check("stats_clr2_stall", 32'(stall_cnt),        32'h0);
    tick();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
